// File: rtl/jtag_debug_control.sv
// jtag_debug_control: cpu_clk-oversampled JTAG TAP with core halt/reset control and IMEM/DMEM word access
module jtag_debug_control #(
  parameter logic [31:0] IDCODE = 32'h5236_4001,
  parameter int IR_WIDTH = 4
) (
  input  logic        cpu_clk,
  input  logic        sys_rstn,
  input  logic        jtag_tck,
  input  logic        jtag_tms,
  input  logic        jtag_tdi,
  input  logic        jtag_trst,
  output logic        jtag_tdo,
  output logic [63:0] cpu_imem_addr,
  output logic [63:0] cpu_debug_to_imem_data,
  input  logic [63:0] cpu_imem_to_debug_data,
  input  logic        cpu_imem_to_debug_data_ready,
  output logic        cpu_imem_ce,
  output logic        cpu_imem_we,
  output logic [63:0] cpu_dmem_addr,
  output logic [63:0] cpu_debug_to_dmem_data,
  input  logic [63:0] cpu_dmem_to_debug_data,
  input  logic        cpu_dmem_to_debug_data_ready,
  output logic        cpu_dmem_ce,
  output logic        cpu_dmem_we,
  output logic        cpu_resetn_cpu,
  output logic        cpu_halt_cpu
);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;
  tap_e tap_q, tap_d;
  logic [2:0] tck_sync_q, tck_sync_d;
  logic [1:0] tms_sync_q, tms_sync_d, tdi_sync_q, tdi_sync_d, trst_sync_q, trst_sync_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sh_q, ir_sh_d;
  logic [63:0] dr_q, dr_d, ia_q, ia_d, id_q, id_d, da_q, da_d, dd_q, dd_d;
  logic [63:0] imem_rl_q, imem_rl_d, dmem_rl_q, dmem_rl_d, dr_cap;
  logic tdo_q, tdo_d, halt_q, halt_d, resetn_q, resetn_d;
  logic imem_rdy_q, imem_rdy_d, dmem_rdy_q, dmem_rdy_d;
  logic im_wp_q, im_wp_d, im_rp_q, im_rp_d, dm_wp_q, dm_wp_d, dm_rp_q, dm_rp_d;
  logic im_ce_q, im_ce_d, im_we_q, im_we_d, dm_ce_q, dm_ce_d, dm_we_q, dm_we_d;
  logic tck_rise, tck_fall, tms, tdi, trst_n, upd;
  logic sel_id, sel_ctrl, sel_ia, sel_idat, sel_da, sel_dd;
  logic iw, irn, dw, drn;
  logic [6:0] dr_len;
  assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
  assign tms = tms_sync_q[1];
  assign tdi = tdi_sync_q[1];
  assign trst_n = trst_sync_q[1];
  assign sel_id = ir_q == IR_WIDTH'(1);
  assign sel_ctrl = ir_q == IR_WIDTH'(2);
  assign sel_ia = ir_q == IR_WIDTH'(3);
  assign sel_idat = ir_q == IR_WIDTH'(4);
  assign sel_da = ir_q == IR_WIDTH'(5);
  assign sel_dd = ir_q == IR_WIDTH'(6);
  assign upd = tck_fall && tap_q == UPD_DR;
  assign jtag_tdo = tdo_q;
  assign cpu_imem_addr = ia_q;
  assign cpu_debug_to_imem_data = id_q;
  assign cpu_dmem_addr = da_q;
  assign cpu_debug_to_dmem_data = dd_q;
  assign cpu_imem_ce = im_ce_q;
  assign cpu_imem_we = im_we_q;
  assign cpu_dmem_ce = dm_ce_q;
  assign cpu_dmem_we = dm_we_q;
  assign cpu_resetn_cpu = resetn_q;
  assign cpu_halt_cpu = halt_q;
  always_comb begin
    tap_d = tap_q;
    if (tck_rise)
      case (tap_q)
        TLR:    tap_d = tms ? TLR : RTI;
        RTI:    tap_d = tms ? SEL_DR : RTI;
        SEL_DR: tap_d = tms ? SEL_IR : CAP_DR;
        CAP_DR: tap_d = tms ? EX1_DR : SH_DR;
        SH_DR:  tap_d = tms ? EX1_DR : SH_DR;
        EX1_DR: tap_d = tms ? UPD_DR : PA_DR;
        PA_DR:  tap_d = tms ? EX2_DR : PA_DR;
        EX2_DR: tap_d = tms ? UPD_DR : SH_DR;
        UPD_DR: tap_d = tms ? SEL_DR : RTI;
        SEL_IR: tap_d = tms ? TLR : CAP_IR;
        CAP_IR: tap_d = tms ? EX1_IR : SH_IR;
        SH_IR:  tap_d = tms ? EX1_IR : SH_IR;
        EX1_IR: tap_d = tms ? UPD_IR : PA_IR;
        PA_IR:  tap_d = tms ? EX2_IR : PA_IR;
        EX2_IR: tap_d = tms ? UPD_IR : SH_IR;
        UPD_IR: tap_d = tms ? SEL_DR : RTI;
        default: tap_d = TLR;
      endcase
    if (!trst_n) tap_d = TLR;
  end
  always_comb begin
    tck_sync_d = {tck_sync_q[1:0], jtag_tck};
    tms_sync_d = {tms_sync_q[0], jtag_tms};
    tdi_sync_d = {tdi_sync_q[0], jtag_tdi};
    trst_sync_d = {trst_sync_q[0], jtag_trst};
    dr_len = sel_id ? 7'd32 : sel_ctrl ? 7'd2 : (sel_ia | sel_idat | sel_da | sel_dd) ? 7'd64 : 7'd1;
    dr_cap = sel_id ? {32'b0, IDCODE} : sel_ctrl ? {62'b0, ~resetn_q, halt_q} : sel_ia ? ia_q :
             sel_idat ? imem_rl_q : sel_da ? da_q : sel_dd ? dmem_rl_q : 64'b0;
    ir_d = (tap_q == TLR || !trst_n) ? IR_WIDTH'(1) : (tck_fall && tap_q == UPD_IR) ? ir_sh_q : ir_q;
    ir_sh_d = !tck_rise ? ir_sh_q : tap_q == CAP_IR ? IR_WIDTH'(5) :
              tap_q == SH_IR ? {tdi, ir_sh_q[IR_WIDTH-1:1]} : ir_sh_q;
    dr_d = !tck_rise ? dr_q : tap_q == CAP_DR ? dr_cap :
           tap_q == SH_DR ? (dr_q >> 1) | (64'(tdi) << (dr_len - 7'd1)) : dr_q;
    tdo_d = tck_fall ? (tap_q == SH_IR ? ir_sh_q[0] : tap_q == SH_DR ? dr_q[0] : 1'b0) : tdo_q;
    halt_d = upd && sel_ctrl ? dr_q[0] : halt_q;
    resetn_d = upd && sel_ctrl ? ~dr_q[1] : resetn_q;
    ia_d = upd && sel_ia ? dr_q : ia_q;
    id_d = upd && sel_idat ? dr_q : id_q;
    da_d = upd && sel_da ? dr_q : da_q;
    dd_d = upd && sel_dd ? dr_q : dd_q;
    iw = halt_d & im_wp_q;
    irn = halt_d & ~im_wp_q & im_rp_q;
    dw = halt_d & ~im_wp_q & ~im_rp_q & dm_wp_q;
    drn = halt_d & ~im_wp_q & ~im_rp_q & ~dm_wp_q & dm_rp_q;
    im_wp_d = halt_d & ((upd & sel_idat) | (im_wp_q & ~iw));
    im_rp_d = halt_d & ((upd & sel_ia) | iw | (im_rp_q & ~irn));
    dm_wp_d = halt_d & ((upd & sel_dd) | (dm_wp_q & ~dw));
    dm_rp_d = halt_d & ((upd & sel_da) | dw | (dm_rp_q & ~drn));
    im_ce_d = iw | irn;
    im_we_d = iw;
    dm_ce_d = dw | drn;
    dm_we_d = dw;
    imem_rdy_d = cpu_imem_to_debug_data_ready;
    dmem_rdy_d = cpu_dmem_to_debug_data_ready;
    imem_rl_d = imem_rdy_q ? cpu_imem_to_debug_data : imem_rl_q;
    dmem_rl_d = dmem_rdy_q ? cpu_dmem_to_debug_data : dmem_rl_q;
  end
  always_ff @(posedge cpu_clk) begin
    if (!sys_rstn) begin
      tck_sync_q <= '0;
      tms_sync_q <= '1;
      tdi_sync_q <= '0;
      trst_sync_q <= '1;
      tap_q <= TLR;
      ir_q <= IR_WIDTH'(1);
      ir_sh_q <= '0;
      dr_q <= '0;
      tdo_q <= 1'b0;
      halt_q <= 1'b0;
      resetn_q <= 1'b1;
      ia_q <= '0;
      id_q <= '0;
      da_q <= '0;
      dd_q <= '0;
      imem_rl_q <= '0;
      dmem_rl_q <= '0;
      imem_rdy_q <= 1'b0;
      dmem_rdy_q <= 1'b0;
      im_wp_q <= 1'b0;
      im_rp_q <= 1'b0;
      dm_wp_q <= 1'b0;
      dm_rp_q <= 1'b0;
      im_ce_q <= 1'b0;
      im_we_q <= 1'b0;
      dm_ce_q <= 1'b0;
      dm_we_q <= 1'b0;
    end else begin
      tck_sync_q <= tck_sync_d;
      tms_sync_q <= tms_sync_d;
      tdi_sync_q <= tdi_sync_d;
      trst_sync_q <= trst_sync_d;
      tap_q <= tap_d;
      ir_q <= ir_d;
      ir_sh_q <= ir_sh_d;
      dr_q <= dr_d;
      tdo_q <= tdo_d;
      halt_q <= halt_d;
      resetn_q <= resetn_d;
      ia_q <= ia_d;
      id_q <= id_d;
      da_q <= da_d;
      dd_q <= dd_d;
      imem_rl_q <= imem_rl_d;
      dmem_rl_q <= dmem_rl_d;
      imem_rdy_q <= imem_rdy_d;
      dmem_rdy_q <= dmem_rdy_d;
      im_wp_q <= im_wp_d;
      im_rp_q <= im_rp_d;
      dm_wp_q <= dm_wp_d;
      dm_rp_q <= dm_rp_d;
      im_ce_q <= im_ce_d;
      im_we_q <= im_we_d;
      dm_ce_q <= dm_ce_d;
      dm_we_q <= dm_we_d;
    end
  end
endmodule

// File: tb/tb_jtag_debug_control.sv
// tb_jtag_debug_control: directed JTAG scans against a RAM model for jtag_debug_control
module tb_jtag_debug_control;
  logic cpu_clk = 1'b0, sys_rstn = 1'b0;
  logic jtag_tck = 1'b0, jtag_tms = 1'b1, jtag_tdi = 1'b0, jtag_trst = 1'b1, jtag_tdo;
  logic [63:0] cpu_imem_addr, cpu_debug_to_imem_data, cpu_imem_to_debug_data;
  logic [63:0] cpu_dmem_addr, cpu_debug_to_dmem_data, cpu_dmem_to_debug_data;
  logic cpu_imem_to_debug_data_ready, cpu_imem_ce, cpu_imem_we;
  logic cpu_dmem_to_debug_data_ready, cpu_dmem_ce, cpu_dmem_we;
  logic cpu_resetn_cpu, cpu_halt_cpu;
  logic [63:0] imem [16];
  logic [63:0] dmem [16];
  int ice_n = 0, iwe_n = 0, dce_n = 0, dwe_n = 0, both_n = 0;
  int errors = 0, checks = 0;
  localparam logic [63:0] IM_INIT = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DM_INIT = 64'h0BAD_F00D_CAFE_0001;
  jtag_debug_control dut (
    .cpu_clk(cpu_clk), .sys_rstn(sys_rstn),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_trst(jtag_trst), .jtag_tdo(jtag_tdo),
    .cpu_imem_addr(cpu_imem_addr), .cpu_debug_to_imem_data(cpu_debug_to_imem_data),
    .cpu_imem_to_debug_data(cpu_imem_to_debug_data), .cpu_imem_to_debug_data_ready(cpu_imem_to_debug_data_ready),
    .cpu_imem_ce(cpu_imem_ce), .cpu_imem_we(cpu_imem_we),
    .cpu_dmem_addr(cpu_dmem_addr), .cpu_debug_to_dmem_data(cpu_debug_to_dmem_data),
    .cpu_dmem_to_debug_data(cpu_dmem_to_debug_data), .cpu_dmem_to_debug_data_ready(cpu_dmem_to_debug_data_ready),
    .cpu_dmem_ce(cpu_dmem_ce), .cpu_dmem_we(cpu_dmem_we),
    .cpu_resetn_cpu(cpu_resetn_cpu), .cpu_halt_cpu(cpu_halt_cpu)
  );
  always #5 cpu_clk = ~cpu_clk;
  assign cpu_imem_to_debug_data_ready = cpu_imem_ce & ~cpu_imem_we;
  assign cpu_dmem_to_debug_data_ready = cpu_dmem_ce & ~cpu_dmem_we;
  always @(posedge cpu_clk) begin
    if (!sys_rstn) begin
      imem[2] <= IM_INIT;
      dmem[1] <= DM_INIT;
    end else begin
      if (cpu_imem_ce && cpu_imem_we) imem[cpu_imem_addr[6:3]] <= cpu_debug_to_imem_data;
      if (cpu_imem_ce && !cpu_imem_we) cpu_imem_to_debug_data <= imem[cpu_imem_addr[6:3]];
      if (cpu_dmem_ce && cpu_dmem_we) dmem[cpu_dmem_addr[6:3]] <= cpu_debug_to_dmem_data;
      if (cpu_dmem_ce && !cpu_dmem_we) cpu_dmem_to_debug_data <= dmem[cpu_dmem_addr[6:3]];
    end
    ice_n <= ice_n + int'(cpu_imem_ce);
    iwe_n <= iwe_n + int'(cpu_imem_ce & cpu_imem_we);
    dce_n <= dce_n + int'(cpu_dmem_ce);
    dwe_n <= dwe_n + int'(cpu_dmem_ce & cpu_dmem_we);
    both_n <= both_n + int'(cpu_imem_ce & cpu_dmem_ce);
  end
  task automatic tck(input logic tms, input logic tdi, output logic o);
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (4) @(negedge cpu_clk);
    o = jtag_tdo;
    jtag_tck = 1'b1;
    repeat (4) @(negedge cpu_clk);
    jtag_tck = 1'b0;
  endtask
  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    logic o;
    dout = '0;
    tck(1'b1, 1'b0, o);
    tck(1'b0, 1'b0, o);
    tck(1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, din[i], o);
      dout[i] = o;
    end
    tck(1'b1, 1'b0, o);
    tck(1'b0, 1'b0, o);
    repeat (12) @(negedge cpu_clk);
  endtask
  task automatic shift_ir(input logic [3:0] din, output logic [3:0] dout);
    logic o;
    dout = '0;
    tck(1'b1, 1'b0, o);
    tck(1'b1, 1'b0, o);
    tck(1'b0, 1'b0, o);
    tck(1'b0, 1'b0, o);
    for (int i = 0; i < 4; i++) begin
      tck(i == 3, din[i], o);
      dout[i] = o;
    end
    tck(1'b1, 1'b0, o);
    tck(1'b0, 1'b0, o);
  endtask
  task automatic test_reset;
    logic o;
    logic [63:0] d;
    sys_rstn = 1'b0;
    repeat (4) @(negedge cpu_clk);
    checks += 6;
    if (jtag_tdo !== 1'b0) begin errors++; $display("FAIL rst_tdo got=%b exp=0", jtag_tdo); end
    if (cpu_halt_cpu !== 1'b0) begin errors++; $display("FAIL rst_halt got=%b exp=0", cpu_halt_cpu); end
    if (cpu_resetn_cpu !== 1'b1) begin errors++; $display("FAIL rst_resetn got=%b exp=1", cpu_resetn_cpu); end
    if ({cpu_imem_ce, cpu_imem_we, cpu_dmem_ce, cpu_dmem_we} !== 4'b0) begin
      errors++; $display("FAIL rst_strobes got=%b exp=0000", {cpu_imem_ce, cpu_imem_we, cpu_dmem_ce, cpu_dmem_we});
    end
    if (cpu_imem_addr !== 64'h0) begin errors++; $display("FAIL rst_iaddr got=%h exp=0", cpu_imem_addr); end
    if (cpu_dmem_addr !== 64'h0) begin errors++; $display("FAIL rst_daddr got=%h exp=0", cpu_dmem_addr); end
    sys_rstn = 1'b1;
    repeat (3) @(negedge cpu_clk);
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, o);
    tck(1'b0, 1'b0, o);
    shift_dr(64'h0, 32, d);
    checks++;
    if (d[31:0] !== 32'h5236_4001) begin errors++; $display("FAIL idcode got=%h exp=52364001", d[31:0]); end
  endtask
  task automatic test_ir_capture;
    logic [3:0] c;
    shift_ir(4'hF, c);
    checks++;
    if (c !== 4'b0101) begin errors++; $display("FAIL ir_capture got=%b exp=0101", c); end
  endtask
  task automatic test_ctrl;
    logic [3:0] c;
    logic [63:0] d;
    shift_ir(4'h2, c);
    shift_dr(64'h1, 2, d);
    checks += 3;
    if (d[1:0] !== 2'b00) begin errors++; $display("FAIL ctrl_cap0 got=%b exp=00", d[1:0]); end
    if (cpu_halt_cpu !== 1'b1) begin errors++; $display("FAIL ctrl_halt1 got=%b exp=1", cpu_halt_cpu); end
    if (cpu_resetn_cpu !== 1'b1) begin errors++; $display("FAIL ctrl_resetn1 got=%b exp=1", cpu_resetn_cpu); end
    shift_dr(64'h2, 2, d);
    checks += 3;
    if (d[1:0] !== 2'b01) begin errors++; $display("FAIL ctrl_cap1 got=%b exp=01", d[1:0]); end
    if (cpu_halt_cpu !== 1'b0) begin errors++; $display("FAIL ctrl_halt0 got=%b exp=0", cpu_halt_cpu); end
    if (cpu_resetn_cpu !== 1'b0) begin errors++; $display("FAIL ctrl_resetn0 got=%b exp=0", cpu_resetn_cpu); end
    shift_dr(64'h1, 2, d);
    checks += 2;
    if (d[1:0] !== 2'b10) begin errors++; $display("FAIL ctrl_cap2 got=%b exp=10", d[1:0]); end
    if (cpu_halt_cpu !== 1'b1) begin errors++; $display("FAIL ctrl_halt2 got=%b exp=1", cpu_halt_cpu); end
  endtask
  task automatic test_imem;
    logic [3:0] c;
    logic [63:0] d;
    int ic, iw, dc;
    ic = ice_n; iw = iwe_n; dc = dce_n;
    shift_ir(4'h3, c);
    shift_dr(64'h10, 64, d);
    checks += 4;
    if (d !== 64'h0) begin errors++; $display("FAIL iaddr_cap got=%h exp=0", d); end
    if (cpu_imem_addr !== 64'h10) begin errors++; $display("FAIL iaddr got=%h exp=10", cpu_imem_addr); end
    if (ice_n - ic !== 1) begin errors++; $display("FAIL iaddr_ce got=%0d exp=1", ice_n - ic); end
    if (iwe_n - iw !== 0) begin errors++; $display("FAIL iaddr_we got=%0d exp=0", iwe_n - iw); end
    ic = ice_n; iw = iwe_n;
    shift_ir(4'h4, c);
    shift_dr(64'hAAAA_5555_0000_FFFF, 64, d);
    checks += 5;
    if (d !== IM_INIT) begin errors++; $display("FAIL idata_cap got=%h exp=%h", d, IM_INIT); end
    if (ice_n - ic !== 2) begin errors++; $display("FAIL idata_ce got=%0d exp=2", ice_n - ic); end
    if (iwe_n - iw !== 1) begin errors++; $display("FAIL idata_we got=%0d exp=1", iwe_n - iw); end
    if (imem[2] !== 64'hAAAA_5555_0000_FFFF) begin errors++; $display("FAIL idata_ram got=%h exp=aaaa55550000ffff", imem[2]); end
    if (dce_n - dc !== 0) begin errors++; $display("FAIL idata_dce got=%0d exp=0", dce_n - dc); end
    shift_dr(64'hAAAA_5555_0000_FFFF, 64, d);
    checks++;
    if (d !== 64'hAAAA_5555_0000_FFFF) begin errors++; $display("FAIL idata_recap got=%h exp=aaaa55550000ffff", d); end
  endtask
  task automatic test_dmem;
    logic [3:0] c;
    logic [63:0] d;
    int dc, dw, ic;
    ic = ice_n;
    shift_ir(4'h5, c);
    shift_dr(64'h8, 64, d);
    checks++;
    if (cpu_dmem_addr !== 64'h8) begin errors++; $display("FAIL daddr got=%h exp=8", cpu_dmem_addr); end
    dc = dce_n; dw = dwe_n;
    shift_ir(4'h6, c);
    shift_dr(64'hDEAD_BEEF_0123_4567, 64, d);
    checks += 5;
    if (d !== DM_INIT) begin errors++; $display("FAIL ddata_cap got=%h exp=%h", d, DM_INIT); end
    if (dce_n - dc !== 2) begin errors++; $display("FAIL ddata_ce got=%0d exp=2", dce_n - dc); end
    if (dwe_n - dw !== 1) begin errors++; $display("FAIL ddata_we got=%0d exp=1", dwe_n - dw); end
    if (dmem[1] !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL ddata_ram got=%h exp=deadbeef01234567", dmem[1]); end
    if (ice_n - ic !== 0) begin errors++; $display("FAIL ddata_ice got=%0d exp=0", ice_n - ic); end
    shift_dr(64'hDEAD_BEEF_0123_4567, 64, d);
    checks++;
    if (d !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL ddata_recap got=%h exp=deadbeef01234567", d); end
  endtask
  task automatic test_no_halt;
    logic [3:0] c;
    logic [63:0] d;
    int dc;
    shift_ir(4'h2, c);
    shift_dr(64'h0, 2, d);
    checks += 2;
    if (d[1:0] !== 2'b01) begin errors++; $display("FAIL nohalt_ctrl got=%b exp=01", d[1:0]); end
    if (cpu_halt_cpu !== 1'b0) begin errors++; $display("FAIL nohalt_halt got=%b exp=0", cpu_halt_cpu); end
    dc = dce_n;
    shift_ir(4'h6, c);
    shift_dr(64'h1234, 64, d);
    checks += 3;
    if (d !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL nohalt_cap got=%h exp=deadbeef01234567", d); end
    if (dce_n - dc !== 0) begin errors++; $display("FAIL nohalt_ce got=%0d exp=0", dce_n - dc); end
    if (cpu_debug_to_dmem_data !== 64'h1234) begin errors++; $display("FAIL nohalt_wdata got=%h exp=1234", cpu_debug_to_dmem_data); end
  endtask
  task automatic test_bypass;
    logic [3:0] c;
    logic [63:0] d;
    shift_ir(4'hF, c);
    shift_dr(64'b01011, 5, d);
    checks++;
    if (d[4:0] !== 5'b10110) begin errors++; $display("FAIL bypass got=%b exp=10110", d[4:0]); end
    shift_ir(4'h9, c);
    shift_dr(64'b01011, 5, d);
    checks++;
    if (d[4:0] !== 5'b10110) begin errors++; $display("FAIL bypass_unk got=%b exp=10110", d[4:0]); end
  endtask
  task automatic test_trst;
    logic [3:0] c;
    logic [63:0] d;
    logic o;
    shift_ir(4'h2, c);
    shift_dr(64'h1, 2, d);
    shift_ir(4'hF, c);
    tck(1'b1, 1'b0, o);
    tck(1'b0, 1'b0, o);
    tck(1'b0, 1'b0, o);
    tck(1'b0, 1'b1, o);
    tck(1'b0, 1'b0, o);
    jtag_trst = 1'b0;
    repeat (5) @(negedge cpu_clk);
    jtag_trst = 1'b1;
    repeat (5) @(negedge cpu_clk);
    checks++;
    if (cpu_halt_cpu !== 1'b1) begin errors++; $display("FAIL trst_halt got=%b exp=1", cpu_halt_cpu); end
    tck(1'b0, 1'b0, o);
    shift_dr(64'h0, 32, d);
    checks++;
    if (d[31:0] !== 32'h5236_4001) begin errors++; $display("FAIL trst_ir got=%h exp=52364001", d[31:0]); end
  endtask
  task automatic test_back_to_back;
    checks++;
    if (both_n !== 0) begin errors++; $display("FAIL dual_strobe got=%0d exp=0", both_n); end
    sys_rstn = 1'b0;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    checks += 3;
    if (cpu_halt_cpu !== 1'b0) begin errors++; $display("FAIL rst2_halt got=%b exp=0", cpu_halt_cpu); end
    if (cpu_dmem_addr !== 64'h0) begin errors++; $display("FAIL rst2_daddr got=%h exp=0", cpu_dmem_addr); end
    if (cpu_debug_to_dmem_data !== 64'h0) begin errors++; $display("FAIL rst2_wdata got=%h exp=0", cpu_debug_to_dmem_data); end
  endtask
  initial begin
    test_reset;
    test_ir_capture;
    test_ctrl;
    test_imem;
    test_dmem;
    test_no_halt;
    test_bypass;
    test_trst;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
